mem_uart_ctrl: RTL and testbench

//  CPU-side memory master that serialises load/store requests into the UART RAM byte protocol and reassembles read replies.

---
 rtl/mem_uart_ctrl_pkg.sv | 29 ++
 rtl/mem_uart_txmux.sv | 30 +++
 rtl/mem_uart_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_uart_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_uart_ctrl_pkg.sv
// Shared state encoding, default header bytes and the write-MSB helper for the UART memory master.
package mem_uart_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR,
      S_ADDR,
      S_AMSB,
      S_MASK,
      S_WDATA,
      S_WMSB,
      S_RDATA,
      S_DONE
   } state_t;

   localparam logic [7:0] HDR_RD_DEF = 8'hC0;
   localparam logic [7:0] HDR_WR_DEF = 8'h80;

   // Bit 7 of each data lane that is part of the access; lanes above len read 0.
   function automatic logic [3:0] msb_mask(input logic [31:0] v, input logic [1:0] len);
      logic [3:0] m;
      m = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         m[i] = v[8*i+7] & (2'(i) <= len);
      end
      return m;
   endfunction

endpackage

// File: rtl/mem_uart_txmux.sv
// Frame byte selector: picks the outgoing UART byte from FSM state, lane counter and latched request.
module mem_uart_txmux
   import mem_uart_ctrl_pkg::*;
#(
   parameter logic [7:0] HDR_RD = HDR_RD_DEF,
   parameter logic [7:0] HDR_WR = HDR_WR_DEF
)(
   input  logic [3:0]  state,
   input  logic [1:0]  cnt,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [1:0]  len,
   input  logic [31:0] wdata,
   output logic [7:0]  tx_byte
);

   always_comb begin
      tx_byte = 8'h00;
      case (state_t'(state))
         S_HDR:   tx_byte = we ? HDR_WR : HDR_RD;
         S_ADDR:  tx_byte = {1'b0, addr[{cnt, 3'b000} +: 7]};
         S_AMSB:  tx_byte = {4'b0000, addr[31], addr[23], addr[15], addr[7]};
         S_MASK:  tx_byte = {6'b000000, len};
         S_WDATA: tx_byte = {1'b0, wdata[{cnt, 3'b000} +: 7]};
         S_WMSB:  tx_byte = {4'b0000, msb_mask(wdata, len)};
         default: tx_byte = 8'h00;
      endcase
   end

endmodule

// File: rtl/mem_uart_ctrl.sv
// CPU memory master speaking the UART RAM byte protocol; one request in flight.
// Optional MEM_UART_TIMEOUT_EN adds a per-byte read-reply timeout that reports via resp_err.
//
// state   | meaning
// S_IDLE  | ready for a CPU request
// S_HDR   | sending read/write header
// S_ADDR  | sending address low-7 segments, cnt 0..3
// S_AMSB  | sending address bit-7 collection byte
// S_MASK  | sending length byte
// S_WDATA | sending write data low-7 segments, cnt 0..len
// S_WMSB  | sending write data bit-7 collection byte
// S_RDATA | collecting read reply bytes, cnt 0..len
// S_DONE  | one-cycle response pulse
module mem_uart_ctrl
   import mem_uart_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter logic [7:0]  HDR_RD      = HDR_RD_DEF,
   parameter logic [7:0]  HDR_WR      = HDR_WR_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_len,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready
);

   state_t      state, state_nxt;
   logic [1:0]  cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [1:0]  r_len;
   logic [31:0] r_wdata;
   logic [7:0]  tx_byte;
   logic        accept, tx_fire, rx_take, tmo_expired, resp_err_q;

   assign accept   = (state == S_IDLE) && req_valid;
   assign tx_fire  = tx_valid && tx_ready;
   assign rx_take  = (state == S_RDATA) && rx_valid;
   assign rx_ready = 1'b1;
   assign resp_err = resp_err_q;

   mem_uart_txmux #(.HDR_RD(HDR_RD), .HDR_WR(HDR_WR)) u_txmux (
      .state   (state),
      .cnt     (cnt),
      .we      (r_we),
      .addr    (r_addr),
      .len     (r_len),
      .wdata   (r_wdata),
      .tx_byte (tx_byte)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid) state_nxt = S_HDR;
         S_HDR:   if (tx_ready) state_nxt = S_ADDR;
         S_ADDR:  if (tx_ready && cnt == 2'd3) state_nxt = S_AMSB;
         S_AMSB:  if (tx_ready) state_nxt = S_MASK;
         S_MASK:  if (tx_ready) state_nxt = r_we ? S_WDATA : S_RDATA;
         S_WDATA: if (tx_ready && cnt == r_len) state_nxt = S_WMSB;
         S_WMSB:  if (tx_ready) state_nxt = S_DONE;
         S_RDATA: if ((rx_valid && cnt == r_len) || tmo_expired) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == S_IDLE);
      resp_valid = (state == S_DONE);
      tx_valid   = state inside {S_HDR, S_ADDR, S_AMSB, S_MASK, S_WDATA, S_WMSB};
      tx_data    = tx_byte;
   end

   // cnt restarts on every state change, so it only ever walks 0..len (or 0..3 for the address).
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt        <= 2'd0;
         r_we       <= 1'b0;
         r_addr     <= 32'd0;
         r_len      <= 2'd0;
         r_wdata    <= 32'd0;
         resp_rdata <= 32'd0;
         resp_err_q <= 1'b0;
      end else begin
         if (state_nxt != state)
            cnt <= 2'd0;
         else if ((tx_fire && (state inside {S_ADDR, S_WDATA})) || rx_take)
            cnt <= cnt + 2'd1;
         if (accept) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_len      <= req_len;
            r_wdata    <= req_wdata;
            resp_rdata <= 32'd0;
            resp_err_q <= 1'b0;
         end
         if (rx_take)
            resp_rdata[{cnt, 3'b000} +: 8] <= rx_data;
         if (tmo_expired)
            resp_err_q <= 1'b1;
      end
   end

`ifdef MEM_UART_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   // Reloads outside S_RDATA and on every reply byte; expires after TIMEOUT_CYC quiet cycles.
   always_ff @(posedge clk) begin
      if (!rst)
         tmo_cnt <= 32'd0;
      else if ((state != S_RDATA) || rx_valid)
         tmo_cnt <= 32'(TIMEOUT_CYC - 1);
      else if (tmo_cnt != 32'd0)
         tmo_cnt <= tmo_cnt - 32'd1;
   end

   assign tmo_expired = (state == S_RDATA) && !rx_valid && (tmo_cnt == 32'd0);
`else
   // No reply timeout in this build: S_RDATA waits for every byte.
   assign tmo_expired = (TIMEOUT_CYC == 0) & 1'b0;
`endif

endmodule

// File: tb/tb_mem_uart_ctrl.sv
// Self-checking bench for mem_uart_ctrl: frame/response model from the protocol rules plus directed literal cases.
module tb_mem_uart_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic [1:0]  req_len = 2'd0;
   logic        req_ready, resp_valid, resp_err, tx_valid, rx_ready;
   logic [31:0] resp_rdata;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0, rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;

   always #5 clk = ~clk;

   mem_uart_ctrl #(.TIMEOUT_CYC(50)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
   );

   int          total = 0, bad = 0, cyc = 0;
   logic [7:0]  exp_tx[$];
   logic        chk_en = 1'b0, busy = 1'b0, resp_next = 1'b0, cur_we = 1'b0;
   logic [1:0]  cur_len = 2'd0;
   int          rx_seen = 0, pres_cyc = 0, resp_cyc = 0, tx_mode = 0;
   logic [31:0] exp_rdata = 32'd0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Model of the byte frame, computed from the protocol rules with plain arithmetic.
   task automatic build_frame(input logic we, input logic [31:0] a, input logic [1:0] len,
                              input logic [31:0] d);
      int m;
      exp_tx.push_back(we ? 8'h80 : 8'hC0);
      for (int i = 0; i < 4; i++) exp_tx.push_back(8'((a >> (8*i)) & 32'h7F));
      m = 0;
      for (int i = 0; i < 4; i++) m = m + int'((a >> (8*i+7)) & 32'h1) * (1 << i);
      exp_tx.push_back(8'(m));
      exp_tx.push_back(8'(len));
      if (we) begin
         m = 0;
         for (int i = 0; i <= int'(len); i++) begin
            exp_tx.push_back(8'((d >> (8*i)) & 32'h7F));
            m = m + int'((d >> (8*i+7)) & 32'h1) * (1 << i);
         end
         exp_tx.push_back(8'(m));
      end
   endtask

   // Per-cycle compare against the model; the model advances on observed handshakes.
   always @(negedge clk) begin
      if (chk_en) begin
         logic expv;
         expv = resp_next;
         resp_next = 1'b0;
         check("req_ready", 32'(req_ready), 32'(!busy));
         check("rx_ready", 32'(rx_ready), 32'd1);
         check("resp_valid", 32'(resp_valid), 32'(expv));
         if (expv) begin
            check("resp_rdata", resp_rdata, exp_rdata);
            check("resp_err", 32'(resp_err), 32'd0);
            resp_cyc = cyc;
            busy = 1'b0;
         end
         if (busy && !cur_we && exp_tx.size() == 0 && rx_valid) begin
            exp_rdata = exp_rdata | (32'(rx_data) << (8*rx_seen));
            rx_seen++;
            if (rx_seen == int'(cur_len) + 1) resp_next = 1'b1;
         end
         check("tx_valid", 32'(tx_valid), 32'(busy && exp_tx.size() != 0));
         if (tx_valid && exp_tx.size() != 0) begin
            check("tx_data", 32'(tx_data), 32'(exp_tx[0]));
            if (tx_ready) begin
               void'(exp_tx.pop_front());
               if (exp_tx.size() == 0 && cur_we) resp_next = 1'b1;
            end
         end
         if (req_valid && req_ready && !busy) begin
            busy = 1'b1;
            pres_cyc = cyc;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (tx_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic present(input logic we, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] wdata);
      int n;
      cur_we = we; cur_len = len; rx_seen = 0; exp_rdata = 32'd0;
      n = 0;
      while (busy && n < 200) begin @(posedge clk); #1; n++; end
      if (busy) check("idle wait timeout", 32'd1, 32'd0);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = 1'($urandom_range(0, 1)); req_addr = $urandom;
      req_len = 2'($urandom_range(0, 3)); req_wdata = $urandom;
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wdata, input logic [31:0] rx_word,
                         input int gap_max, input logic use_model);
      int n;
      if (use_model) build_frame(we, addr, len, wdata);
      present(we, addr, len, wdata);
      n = 0;
      while (exp_tx.size() != 0 && n < 400) begin
         if (gap_max > 0 && exp_tx.size() > 1 && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b1; rx_data = 8'($urandom);
         end else rx_valid = 1'b0;
         @(posedge clk); #1; n++;
      end
      rx_valid = 1'b0;
      if (exp_tx.size() != 0) check("tx drain timeout", 32'(exp_tx.size()), 32'd0);
      if (!we) begin
         for (int k = 0; k <= int'(len); k++) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            rx_valid = 1'b1; rx_data = rx_word[8*k +: 8];
            @(posedge clk); #1;
            rx_valid = 1'b0;
         end
      end
      n = 0;
      while (busy && n < 50) begin @(posedge clk); #1; n++; end
      if (busy) check("resp timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst tx_valid", 32'(tx_valid), 32'd0);
      check("rst tx_data", 32'(tx_data), 32'd0);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst resp_rdata", resp_rdata, 32'd0);
      check("rst resp_err", 32'(resp_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      chk_en = 1'b1;

      // 1: write word, unstalled
      tx_mode = 0;
      exp_tx = '{8'h80, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00};
      do_req(1'b1, 32'h0000_0104, 2'd3, 32'h0000_0041, 32'd0, 0, 1'b0);
      check("t1 resp latency", 32'(resp_cyc - pres_cyc), 32'd13);

      // 2: read byte
      exp_tx = '{8'hC0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      do_req(1'b0, 32'h0000_0100, 2'd0, 32'd0, 32'h0000_005A, 0, 1'b0);
      check("t2 rdata", resp_rdata, 32'h0000_005A);

      // 3: read half with all address MSBs set
      exp_tx = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h01};
      do_req(1'b0, 32'h8080_8080, 2'd1, 32'd0, 32'h0000_80FF, 2, 1'b0);
      check("t3 rdata", resp_rdata, 32'h0000_80FF);

      // 4: same write as test 1 with alternating tx_ready
      tx_mode = 1;
      exp_tx = '{8'h80, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00};
      do_req(1'b1, 32'h0000_0104, 2'd3, 32'h0000_0041, 32'd0, 0, 1'b0);
      check("t4 rdata after write", resp_rdata, 32'd0);

      // 5: reset three bytes into a write, then a fresh read
      tx_mode = 0;
      build_frame(1'b1, 32'hDEAD_BEEF, 2'd3, 32'hCAFE_F00D);
      present(1'b1, 32'hDEAD_BEEF, 2'd3, 32'hCAFE_F00D);
      n = 0;
      while (exp_tx.size() > 9 && n < 50) begin @(posedge clk); #1; n++; end
      check("t5 bytes before reset", 32'(exp_tx.size()), 32'd9);
      chk_en = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("t5 tx_valid", 32'(tx_valid), 32'd0);
      check("t5 req_ready", 32'(req_ready), 32'd1);
      check("t5 resp_valid", 32'(resp_valid), 32'd0);
      exp_tx.delete();
      busy = 1'b0;
      resp_next = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;
      do_req(1'b0, 32'h1234_5678, 2'd2, 32'd0, 32'h00A1_B2C3, 1, 1'b1);
      check("t5 read rdata", resp_rdata, 32'h00A1_B2C3);

      // randomized requests and stall patterns
      repeat (40) begin
         tx_mode = $urandom_range(0, 2);
         do_req(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom,
                $urandom, $urandom_range(0, 3), 1'b1);
      end

`ifdef MEM_UART_TIMEOUT_EN
      // 6: read word with only two reply bytes
      tx_mode = 0;
      chk_en = 1'b0;
      present(1'b0, 32'h0000_0200, 2'd3, 32'd0);
      n = 0;
      while (tx_valid && n < 100) begin @(posedge clk); #1; n++; end
      rx_valid = 1'b1; rx_data = 8'h11;
      @(posedge clk); #1;
      rx_data = 8'h22;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 200) begin @(negedge clk); n++; end
      check("t6 resp_valid", 32'(resp_valid), 32'd1);
      check("t6 resp_err", 32'(resp_err), 32'd1);
      check("t6 rdata", resp_rdata, 32'h0000_2211);
      @(posedge clk); #1;
      busy = 1'b0;
      resp_next = 1'b0;
      chk_en = 1'b1;
`endif

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
